// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU op codes,
// sequencer states, instruction classes and IR field positions.
package cpu_ctrl_pkg;

  // IR field positions
  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaMsb     = 26;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbMsb     = 22;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcMsb     = 18;
  localparam int unsigned RcLsb     = 15;

  // Opcodes
  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpRol  = 5'b01010;
  localparam logic [4:0] OpAddi = 5'b01011;
  localparam logic [4:0] OpAndi = 5'b01100;
  localparam logic [4:0] OpOri  = 5'b01101;
  localparam logic [4:0] OpMul  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  // ALU op codes, shared with the ALU
  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluShr = 4'd4;
  localparam logic [3:0] AluShl = 4'd5;
  localparam logic [3:0] AluRor = 4'd6;
  localparam logic [3:0] AluRol = 4'd7;
  localparam logic [3:0] AluMul = 4'd8;
  localparam logic [3:0] AluDiv = 4'd9;

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted
  } state_e;

  typedef enum logic [2:0] {
    ClsLd, ClsLdi, ClsSt, ClsAluR, ClsAluI, ClsMulDiv, ClsNop, ClsHalt
  } cls_e;

  // Unassigned opcodes fall into the NOP class.
  function automatic cls_e decode_class(logic [4:0] opc);
    cls_e cls;
    if (opc == OpLd) cls = ClsLd;
    else if (opc == OpLdi) cls = ClsLdi;
    else if (opc == OpSt) cls = ClsSt;
    else if (opc >= OpAdd && opc <= OpRol) cls = ClsAluR;
    else if (opc >= OpAddi && opc <= OpOri) cls = ClsAluI;
    else if (opc == OpMul || opc == OpDiv) cls = ClsMulDiv;
    else if (opc == OpHalt) cls = ClsHalt;
    else cls = ClsNop;
    return cls;
  endfunction

  function automatic logic [3:0] alu_op(logic [4:0] opc);
    logic [4:0] rel;
    logic [3:0] op;
    rel = opc - OpAdd;
    op  = AluAdd;
    if (opc >= OpAdd && opc <= OpRol) op = rel[3:0];
    else if (opc == OpAndi) op = AluAnd;
    else if (opc == OpOri) op = AluOr;
    else if (opc == OpMul) op = AluMul;
    else if (opc == OpDiv) op = AluDiv;
    return op;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control bundle between the sequencer and the bus datapath: IR in, strobes out.
interface cpu_control_unit_if;
  logic [31:0] IR;
  logic [15:0] R_out;
  logic [15:0] R_in;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin;
  logic IncPC, Read, Write;
  logic [3:0] operation;
  logic Run;

  modport master (
    input  IR,
    output R_out, R_in,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
    output PCin, MARin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin,
    output IncPC, Read, Write, operation, Run
  );

  modport slave (
    output IR,
    input  R_out, R_in,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin_low, Zin_high, HIin, LOin,
    input  IncPC, Read, Write, operation, Run
  );
endinterface

// File: rtl/reg_field_decoder.sv
// 4-bit register field to 16-bit one-hot select; all-zero when disabled.
module reg_field_decoder (
  input  logic [3:0]  field_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[field_i] = 1'b1;
  end
endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired multi-cycle control sequencer: common fetch T0-T2, then a per-class
// execute sequence T3-T7, all outputs a Moore decode of state plus IR fields.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
(
  input logic              Clock,
  input logic              clear,
  cpu_control_unit_if.master bus
);

  state_e state_q, state_d;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  cls_e       cls;
  logic       rout_en, rin_en;
  logic [3:0] rout_sel, rin_sel;
  logic       unused_ir;

  assign opc       = bus.IR[OpcodeMsb:OpcodeLsb];
  assign ra        = bus.IR[RaMsb:RaLsb];
  assign rb        = bus.IR[RbMsb:RbLsb];
  assign rc        = bus.IR[RcMsb:RcLsb];
  assign cls       = decode_class(opc);
  assign unused_ir = ^bus.IR[RcLsb-1:0];

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) state_q <= StRst;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    rout_en       = 1'b0;
    rout_sel      = '0;
    rin_en        = 1'b0;
    rin_sel       = '0;
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.Cout      = 1'b0;
    bus.PCin      = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin_low   = 1'b0;
    bus.Zin_high  = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.operation = AluAdd;
    bus.Run       = 1'b1;

    unique case (state_q)
      StRst: begin
        bus.Run = 1'b0;
        state_d = StT0;
      end
      StT0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.Zin_low = 1'b1;
        state_d     = StT1;
      end
      StT1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        state_d     = StT2;
      end
      StT2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = StT3;
      end
      StT3: begin
        if (cls == ClsHalt) begin
          state_d = StHalted;
        end else if (cls == ClsNop) begin
          state_d = StT0;
        end else begin
          // MUL/DIV put Ra on Y; every other class puts Rb there.
          rout_en  = 1'b1;
          rout_sel = (cls == ClsMulDiv) ? ra : rb;
          bus.Yin  = 1'b1;
          state_d  = StT4;
        end
      end
      StT4: begin
        bus.Zin_low   = 1'b1;
        bus.operation = alu_op(opc);
        if (cls == ClsAluR) begin
          rout_en  = 1'b1;
          rout_sel = rc;
        end else if (cls == ClsMulDiv) begin
          rout_en      = 1'b1;
          rout_sel     = rb;
          bus.Zin_high = 1'b1;
        end else begin
          bus.Cout      = 1'b1;
          bus.operation = (cls == ClsAluI) ? alu_op(opc) : AluAdd;
        end
        state_d = StT5;
      end
      StT5: begin
        bus.Zlowout = 1'b1;
        state_d     = StT6;
        if (cls == ClsLd || cls == ClsSt) begin
          bus.MARin = 1'b1;
        end else if (cls == ClsMulDiv) begin
          bus.LOin = 1'b1;
        end else begin
          rin_en  = 1'b1;
          rin_sel = ra;
          state_d = StT0;
        end
      end
      StT6: begin
        state_d = StT7;
        if (cls == ClsLd) begin
          bus.Read  = 1'b1;
          bus.MDRin = 1'b1;
        end else if (cls == ClsSt) begin
          rout_en   = 1'b1;
          rout_sel  = ra;
          bus.MDRin = 1'b1;
        end else begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
          state_d      = StT0;
        end
      end
      StT7: begin
        if (cls == ClsLd) begin
          bus.MDRout = 1'b1;
          rin_en     = 1'b1;
          rin_sel    = ra;
        end else begin
          bus.Write = 1'b1;
        end
        state_d = StT0;
      end
      StHalted: begin
        bus.Run = 1'b0;
      end
      default: begin
        bus.Run = 1'b0;
        state_d = StRst;
      end
    endcase
  end

  reg_field_decoder u_rout_dec (
    .field_i  (rout_sel),
    .en_i     (rout_en),
    .onehot_o (bus.R_out)
  );

  reg_field_decoder u_rin_dec (
    .field_i  (rin_sel),
    .en_i     (rin_en),
    .onehot_o (bus.R_in)
  );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed and random instructions
// compared cycle by cycle against a class-level behavioural model.
module tb_cpu_control_unit;

  typedef struct packed {
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
    logic inc_pc, read, write;
    logic [3:0] op;
    logic run;
  } ctl_t;

  logic Clock;
  logic clear;
  int   n_tests;
  int   n_fail;

  cpu_control_unit_if bus_if ();

  cpu_control_unit dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic ctl_t observe();
    ctl_t c;
    c.r_out = bus_if.R_out;     c.r_in = bus_if.R_in;
    c.pc_out = bus_if.PCout;    c.zlow_out = bus_if.Zlowout;
    c.zhigh_out = bus_if.Zhighout; c.mdr_out = bus_if.MDRout;
    c.hi_out = bus_if.HIout;    c.lo_out = bus_if.LOout;
    c.c_out = bus_if.Cout;      c.pc_in = bus_if.PCin;
    c.mar_in = bus_if.MARin;    c.mdr_in = bus_if.MDRin;
    c.ir_in = bus_if.IRin;      c.y_in = bus_if.Yin;
    c.zlow_in = bus_if.Zin_low; c.zhigh_in = bus_if.Zin_high;
    c.hi_in = bus_if.HIin;      c.lo_in = bus_if.LOin;
    c.inc_pc = bus_if.IncPC;    c.read = bus_if.Read;
    c.write = bus_if.Write;     c.op = bus_if.operation;
    c.run = bus_if.Run;
    return c;
  endfunction

  // Instruction length in cycles from T0 (HALT: T0..T3, then HALTED).
  function automatic int latency(logic [31:0] ir);
    int opc;
    opc = int'(ir[31:27]);
    if (opc == 0 || opc == 2) return 8;
    if (opc == 1 || (opc >= 3 && opc <= 13)) return 6;
    if (opc == 14 || opc == 15) return 7;
    return 4;
  endfunction

  // Expected outputs at cycle 'step' (0 = T0) of instruction ir.
  function automatic ctl_t model(logic [31:0] ir, int step);
    ctl_t c;
    int opc;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic [3:0] aop;
    opc   = int'(ir[31:27]);
    ra_oh = 16'd1 << ir[26:23];
    rb_oh = 16'd1 << ir[22:19];
    rc_oh = 16'd1 << ir[18:15];
    c = '0;
    c.run = 1'b1;
    if (step == 0) begin
      c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.zlow_in = 1;
    end else if (step == 1) begin
      c.zlow_out = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1;
    end else if (step == 2) begin
      c.mdr_out = 1; c.ir_in = 1;
    end else if (opc >= 3 && opc <= 13) begin
      if (opc <= 10) aop = 4'(opc - 3);
      else if (opc == 11) aop = 4'd0;
      else if (opc == 12) aop = 4'd2;
      else aop = 4'd3;
      case (step)
        3: begin c.r_out = rb_oh; c.y_in = 1; end
        4: begin
          if (opc <= 10) c.r_out = rc_oh; else c.c_out = 1;
          c.op = aop; c.zlow_in = 1;
        end
        5: begin c.zlow_out = 1; c.r_in = ra_oh; end
        default: ;
      endcase
    end else if (opc <= 2) begin
      case (step)
        3: begin c.r_out = rb_oh; c.y_in = 1; end
        4: begin c.c_out = 1; c.zlow_in = 1; end
        5: begin
          c.zlow_out = 1;
          if (opc == 1) c.r_in = ra_oh; else c.mar_in = 1;
        end
        6: begin
          c.mdr_in = 1;
          if (opc == 0) c.read = 1; else c.r_out = ra_oh;
        end
        7: begin
          if (opc == 0) begin c.mdr_out = 1; c.r_in = ra_oh; end
          else c.write = 1;
        end
        default: ;
      endcase
    end else if (opc == 14 || opc == 15) begin
      case (step)
        3: begin c.r_out = ra_oh; c.y_in = 1; end
        4: begin
          c.r_out = rb_oh; c.zlow_in = 1; c.zhigh_in = 1;
          c.op = (opc == 14) ? 4'd8 : 4'd9;
        end
        5: begin c.zlow_out = 1; c.lo_in = 1; end
        6: begin c.zhigh_out = 1; c.hi_in = 1; end
        default: ;
      endcase
    end
    return c;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Entered in T0; leaves in the state after the instruction's last cycle.
  task automatic run_instr(input logic [31:0] ir, input string name);
    ctl_t got, exp;
    int len;
    bus_if.IR = ir;
    len = latency(ir);
    for (int s = 0; s < len; s++) begin
      got = observe();
      exp = model(ir, s);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s ir=%08h step=T%0d got=%h exp=%h", name, ir, s, got, exp);
      end
      step();
    end
  endtask

  task automatic check_t0(input string name);
    ctl_t got;
    got = observe();
    n_tests++;
    if (got !== model(32'h0, 0)) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, model(32'h0, 0));
    end
  endtask

  task automatic check_zero(input string name);
    ctl_t got;
    got = observe();
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s got=%h exp=0", name, got);
    end
  endtask

  task automatic release_clear();
    @(negedge Clock);
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus_if.IR = 32'h0;
    #1;
    check_zero("reset_state");
    step();
    check_zero("reset_hold");
    release_clear();
    check_t0("reset_release_t0");
  endtask

  task automatic test_directed();
    run_instr(32'h18A18000, "add");
    check_t0("add_latency");
    run_instr(32'h00880005, "ld");
    check_t0("ld_latency");
    run_instr(32'h10800000, "st");
    check_t0("st_latency");
    run_instr(32'h71000000, "mul");
    check_t0("mul_latency");
    run_instr(32'h7A088000, "div");
    check_t0("div_latency");
    run_instr(32'h08800007, "ldi");
    run_instr(32'h5C000000, "addi");
    run_instr(32'hA0000000, "op10100_nop");
    check_t0("nop_latency");
    run_instr(32'hD0000000, "nop");
    run_instr(32'h1F800000, "add_r15");
    run_instr(32'h18000000, "add_r0");
    check_t0("directed_end");
  endtask

  task automatic test_random();
    logic [31:0] ir;
    for (int i = 0; i < 60; i++) begin
      ir = $urandom;
      if (ir[31:27] == 5'd27) ir[31:27] = 5'd26;
      run_instr(ir, "random");
    end
    check_t0("random_end");
  endtask

  task automatic test_reset_mid();
    bus_if.IR = 32'h18A18000;
    for (int i = 0; i < 4; i++) step();
    clear = 1'b1;
    #1;
    check_zero("reset_mid_async");
    step();
    check_zero("reset_mid_hold");
    release_clear();
    check_t0("reset_mid_release_t0");
  endtask

  task automatic test_halt();
    run_instr(32'hD8000000, "halt");
    for (int i = 0; i < 20; i++) begin
      check_zero("halted_hold");
      step();
    end
    clear = 1'b1;
    #1;
    check_zero("halted_clear");
    release_clear();
    check_t0("halted_release_t0");
    run_instr(32'h18A18000, "add_after_halt");
    check_t0("add_after_halt_end");
  endtask

  // At most one bus source at any time.
  always @(negedge Clock) begin
    int srcs;
    srcs = $countones(bus_if.R_out) + int'(bus_if.PCout) + int'(bus_if.Zlowout)
         + int'(bus_if.Zhighout) + int'(bus_if.MDRout) + int'(bus_if.HIout)
         + int'(bus_if.LOout) + int'(bus_if.Cout);
    n_tests++;
    if (srcs > 1) begin
      n_fail++;
      $display("FAIL bus_source_onehot got=%0d sources required<=1 at %0t", srcs, $time);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear   = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
